// File: rtl/morse_message_sequencer.sv
// Sends a latched message of up to four BCD digits, most-significant first, to a
// downstream digit encoder, spacing characters by a programmable inter-character gap.
module morse_message_sequencer #(
  parameter int unsigned CHAR_GAP    = 150_000_000,
  parameter int unsigned ACK_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic [2:0]  num_digits,
  input  logic        abort,
  input  logic        enc_busy,
  output logic        enc_start,
  output logic [3:0]  enc_digit,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  digit_idx,
  output logic [2:0]  state_dbg
);

  // Encoder handshake: enc_start is a one-cycle pulse with enc_digit valid in the same
  // cycle; the encoder acknowledges by raising enc_busy and finishes by dropping it.
  // enc_busy must be seen high within ACK_TIMEOUT cycles counted from the enc_start cycle.
  localparam int ACK_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [ACK_W-1:0] ACK_LAST = ACK_W'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ISSUE     = 3'd1,
    WAIT_ACK  = 3'd2,
    WAIT_DONE = 3'd3,
    GAP       = 3'd4,
    FINISH    = 3'd5
  } state_t;

  state_t           state;
  logic [15:0]      msg;
  logic [31:0]      timer;
  logic [ACK_W-1:0] ack_cnt;
  logic             load_valid;
  logic [1:0]       first_idx;
  logic [1:0]       next_idx;

  function automatic logic load_ok(input logic [15:0] d, input logic [2:0] n);
    logic ok;
    ok = (n != 3'd0) && (n <= 3'd4);
    for (int k = 0; k < 4; k++) begin
      if ((k < int'(n)) && (d[4*k +: 4] > 4'd9)) ok = 1'b0;
    end
    return ok;
  endfunction

  always_comb begin
    load_valid = load_ok(digits_in, num_digits);
    first_idx  = 2'(num_digits - 3'd1);
    next_idx   = digit_idx - 2'd1;
  end

  assign state_dbg = 3'(state);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      msg       <= '0;
      timer     <= '0;
      ack_cnt   <= '0;
      enc_start <= 1'b0;
      enc_digit <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      digit_idx <= '0;
    end else begin
      enc_start <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      if (abort && (state != IDLE)) begin
        state   <= IDLE;
        busy    <= 1'b0;
        timer   <= '0;
        ack_cnt <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (load) begin
              if (load_valid) begin
                msg       <= digits_in;
                digit_idx <= first_idx;
                enc_digit <= digits_in[{first_idx, 2'b00} +: 4];
                enc_start <= 1'b1;
                busy      <= 1'b1;
                state     <= ISSUE;
              end else begin
                err <= 1'b1;
              end
            end
          end
          ISSUE: begin
            // The start cycle itself counts toward the acknowledge window.
            ack_cnt <= ACK_W'(1);
            state   <= WAIT_ACK;
          end
          WAIT_ACK: begin
            if (enc_busy) begin
              ack_cnt <= '0;
              state   <= WAIT_DONE;
            end else if (ack_cnt >= ACK_LAST) begin
              ack_cnt <= '0;
              err     <= 1'b1;
              busy    <= 1'b0;
              state   <= IDLE;
            end else begin
              ack_cnt <= ack_cnt + ACK_W'(1);
            end
          end
          WAIT_DONE: begin
            if (!enc_busy) begin
              if (digit_idx == 2'd0) begin
                done  <= 1'b1;
                state <= FINISH;
              end else begin
                timer <= 32'(CHAR_GAP - 1);
                state <= GAP;
              end
            end
          end
          GAP: begin
            if (timer == 32'd0) begin
              digit_idx <= next_idx;
              enc_digit <= msg[{next_idx, 2'b00} +: 4];
              enc_start <= 1'b1;
              state     <= ISSUE;
            end else begin
              timer <= timer - 32'd1;
            end
          end
          FINISH: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
          default: begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_morse_message_sequencer.sv
// Directed and randomized bench for morse_message_sequencer with a behavioural encoder
// model and a digit scoreboard fed from the message contents.
module tb_morse_message_sequencer;

  localparam int CHAR_GAP    = 20;
  localparam int ACK_TIMEOUT = 16;

  logic        clk;
  logic        rst;
  logic        load;
  logic [15:0] digits_in;
  logic [2:0]  num_digits;
  logic        abort;
  logic        enc_busy;
  logic        enc_start;
  logic [3:0]  enc_digit;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  digit_idx;
  logic [2:0]  state_dbg;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_digit;
  logic [3:0] held_digit = '0;
  int start_cnt = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int busy_cycles = 0;
  int last_start_cyc = 0;
  int last_err_cyc = 0;
  int fall_cyc = 0;
  bit seen_fall = 0;
  bit enc_en = 1;
  int busy_len = 10;
  logic prev_busy = 1'b0;

  morse_message_sequencer #(
    .CHAR_GAP(CHAR_GAP),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .load(load),
    .digits_in(digits_in),
    .num_digits(num_digits),
    .abort(abort),
    .enc_busy(enc_busy),
    .enc_start(enc_start),
    .enc_digit(enc_digit),
    .busy(busy),
    .done(done),
    .err(err),
    .digit_idx(digit_idx),
    .state_dbg(state_dbg)
  );

  // Clock and reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: run did not reach its summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Encoder model: acknowledges in the start cycle, stays busy for busy_len cycles.
  always begin
    @(posedge clk);
    #2;
    if (enc_en && enc_start) begin
      enc_busy = 1'b1;
      repeat (busy_len) @(posedge clk);
      #2;
      enc_busy = 1'b0;
    end
  end

  // Monitor and scoreboard
  always begin
    @(posedge clk);
    #3;
    cyc++;
    if (busy) busy_cycles++;
    if (prev_busy && !enc_busy) begin
      seen_fall = 1'b1;
      fall_cyc  = cyc;
      if (busy) check("digit_hold", enc_digit, held_digit);
    end
    prev_busy = enc_busy;
    if (enc_start) begin
      start_cnt++;
      last_start_cyc = cyc;
      held_digit = enc_digit;
      if (exp_q.size() == 0) begin
        check("spurious_start", 32'(exp_q.size()), 32'd1);
      end else begin
        exp_digit = exp_q.pop_front();
        check("enc_digit", enc_digit, exp_digit);
      end
      // Whole idle cycles strictly between the busy-fall cycle and the start cycle.
      if (seen_fall) check("char_gap", cyc - fall_cyc - 1, CHAR_GAP);
      seen_fall = 1'b0;
    end
    if (done) begin
      done_cnt++;
      seen_fall = 1'b0;
    end
    if (err) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
  end

  // Driver tasks and reference model
  function automatic bit model_valid(input logic [15:0] d, input int n);
    if (n < 1 || n > 4) return 1'b0;
    for (int k = 0; k < n; k++) begin
      if (d[4*k +: 4] >= 4'd10) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic push_msg(input logic [15:0] d, input int n);
    for (int k = n - 1; k >= 0; k--) exp_q.push_back(d[4*k +: 4]);
  endtask

  task automatic do_load(input logic [15:0] d, input int n);
    @(posedge clk);
    #1;
    digits_in  = d;
    num_digits = 3'(n);
    load       = 1'b1;
    seen_fall  = 1'b0;
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int d0;
    int k;
    d0 = done_cnt;
    k  = 0;
    while (done_cnt == d0 && k < budget) begin
      @(posedge clk);
      #4;
      k++;
    end
    repeat (3) @(posedge clk);
    #4;
    check({tag, "_done_count"}, done_cnt - d0, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
    check({tag, "_idle"}, busy, 1'b0);
  endtask

  task automatic wait_enc_busy(input logic lvl, input int budget, input string tag);
    int k;
    k = 0;
    while (enc_busy !== lvl && k < budget) begin
      @(posedge clk);
      #3;
      k++;
    end
    check(tag, enc_busy, lvl);
  endtask

  task automatic invalid_load(input logic [15:0] d, input int n, input string tag);
    int e0, s0, b0;
    e0 = err_cnt;
    s0 = start_cnt;
    b0 = busy_cycles;
    do_load(d, n);
    #2;
    check({tag, "_err_pulse"}, err, 1'b1);
    repeat (4) @(posedge clk);
    #4;
    check({tag, "_err_count"}, err_cnt - e0, 1);
    check({tag, "_no_start"}, start_cnt - s0, 0);
    check({tag, "_busy_low"}, busy_cycles - b0, 0);
  endtask

  initial begin
    int d0, e0, s0, n;
    logic [15:0] d;
    rst        = 1'b0;
    load       = 1'b0;
    abort      = 1'b0;
    enc_busy   = 1'b0;
    digits_in  = '0;
    num_digits = '0;
    #1;
    rst = 1'b1;
    #1;
    check("rst_enc_start", enc_start, 1'b0);
    check("rst_outputs", {enc_digit, busy, done, err, digit_idx}, '0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Three-digit message with gap timing
    busy_len = 10;
    push_msg(16'h0372, 3);
    do_load(16'h0372, 3);
    #2;
    check("start_latency", enc_start, 1'b1);
    check("first_digit_idx", digit_idx, 2'd2);
    check("first_digit", enc_digit, 4'd3);
    wait_done(300, "msg_0372");

    // Rejected loads
    invalid_load(16'h0000, 0, "n_zero");
    invalid_load(16'h00A1, 2, "bad_digit");

    // Acknowledge timeout
    enc_en = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    push_msg(16'h0005, 1);
    do_load(16'h0005, 1);
    for (int k = 0; k < 40 && err_cnt == e0; k++) begin
      @(posedge clk);
      #4;
    end
    repeat (3) @(posedge clk);
    #4;
    check("timeout_err_count", err_cnt - e0, 1);
    check("timeout_latency", last_err_cyc - last_start_cyc, ACK_TIMEOUT);
    check("timeout_no_done", done_cnt - d0, 0);
    check("timeout_idle", busy, 1'b0);
    enc_en = 1'b1;

    // Abort during the gap after the second of four digits
    d0 = done_cnt;
    s0 = start_cnt;
    push_msg(16'h4821, 4);
    do_load(16'h4821, 4);
    for (int k = 0; k < 200 && start_cnt - s0 < 2; k++) begin
      @(posedge clk);
      #4;
    end
    wait_enc_busy(1'b1, 10, "abort_enc_busy_high");
    wait_enc_busy(1'b0, 30, "abort_enc_busy_low");
    repeat (5) @(posedge clk);
    #1;
    check("busy_in_gap", busy, 1'b1);
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    #1;
    check("abort_idle", busy, 1'b0);
    check("abort_no_start", enc_start, 1'b0);
    exp_q.delete();
    repeat (60) @(posedge clk);
    #4;
    check("abort_start_count", start_cnt - s0, 2);
    check("abort_no_done", done_cnt - d0, 0);

    // Reset in WAIT_DONE, then recovery
    push_msg(16'h0035, 2);
    do_load(16'h0035, 2);
    wait_enc_busy(1'b1, 10, "rst_enc_busy_high");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check("midrst_enc_start", enc_start, 1'b0);
    check("midrst_enc_digit", enc_digit, 4'd0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_flags", {done, err}, 2'b00);
    check("midrst_digit_idx", digit_idx, 2'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    wait_enc_busy(1'b0, 30, "rst_enc_release");
    push_msg(16'h0009, 1);
    do_load(16'h0009, 1);
    wait_done(100, "after_reset");

    // Load re-asserted with other digits while busy
    push_msg(16'h1234, 4);
    do_load(16'h1234, 4);
    repeat (5) @(posedge clk);
    #1;
    digits_in  = 16'h5678;
    num_digits = 3'd2;
    load       = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    load = 1'b0;
    wait_done(400, "reload_ignored");

    // Randomized messages against the reference model
    for (int it = 0; it < 10; it++) begin
      n = $urandom_range(0, 5);
      d = '0;
      for (int k = 0; k < 4; k++) begin
        if ($urandom_range(0, 4) == 0) d[4*k +: 4] = 4'($urandom_range(10, 15));
        else d[4*k +: 4] = 4'($urandom_range(0, 9));
      end
      busy_len = $urandom_range(1, 12);
      if (model_valid(d, n)) begin
        push_msg(d, n);
        do_load(d, n);
        wait_done(n * 60 + 60, "rand_msg");
      end else begin
        invalid_load(d, n, "rand_bad");
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/morse_message_sequencer.md
MORSE_MESSAGE_SEQUENCER -- requirements
Module: morse_message_sequencer

Interface
REQ-001 SHALL have parameter CHAR_GAP, default 150_000_000, meaning inter-character gap in clk cycles (1.5 s at 100 MHz).
REQ-002 SHALL have parameter ACK_TIMEOUT, default 16, meaning the maximum number of cycles allowed after enc_start for enc_busy to rise.
REQ-003 SHALL have port clk  input  1  100 MHz system clock; the single clock, all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port load  input  1  request to send a message, sampled only in IDLE.
REQ-006 SHALL have port digits_in  input  16  four BCD digits; digit k = digits_in[4k+3:4k].
REQ-007 SHALL have port num_digits  input  3  count of digits to send; legal range 1..4.
REQ-008 SHALL have port abort  input  1  cancel the message in progress.
REQ-009 SHALL have port enc_busy  input  1  high while the downstream digit encoder is sending.
REQ-010 SHALL have port enc_start  output  1  one-cycle start pulse to the encoder.
REQ-011 SHALL have port enc_digit  output  4  digit presented to the encoder.
REQ-012 SHALL have port busy  output  1  high in every state except IDLE.
REQ-013 SHALL have port done  output  1  one-cycle pulse when the message completes.
REQ-014 SHALL have port err  output  1  one-cycle pulse on rejected load or ack timeout.
REQ-015 SHALL have port digit_idx  output  2  index of the digit currently being sent.

Function
REQ-016 SHALL implement the states IDLE, ISSUE, WAIT_ACK, WAIT_DONE, GAP and FINISH; all outputs SHALL be registered.
REQ-017 SHALL, in IDLE with load=1, latch digits_in and num_digits, set digit_idx=num_digits-1 and go to ISSUE, provided the load is valid.
REQ-018 SHALL treat a load as invalid if num_digits is 0 or greater than 4, or if any active digit (k<num_digits) exceeds 9; on an invalid load SHALL pulse err for one cycle and remain in IDLE.
REQ-019 SHALL send digits most-significant first: index num_digits-1 down to 0.
REQ-020 SHALL, in ISSUE, drive enc_start=1 for exactly one cycle with enc_digit equal to the latched digit[digit_idx], then go to WAIT_ACK.
REQ-021 SHALL assert enc_start in cycle N+1 when load is sampled at edge N.
REQ-022 SHALL hold enc_digit stable from ISSUE until leaving WAIT_DONE.
REQ-023 SHALL, in WAIT_ACK, go to WAIT_DONE on enc_busy=1.
REQ-024 SHALL, if ACK_TIMEOUT cycles elapse in WAIT_ACK without enc_busy=1, pulse err and return to IDLE with no done pulse.
REQ-025 SHALL, in WAIT_DONE, on enc_busy=0 go to FINISH if digit_idx=0, otherwise load the timer with CHAR_GAP-1 and go to GAP.
REQ-026 SHALL, in GAP, decrement the timer; at 0 it SHALL decrement digit_idx and go to ISSUE, so that the gap is exactly CHAR_GAP cycles.
REQ-027 SHALL, in FINISH, pulse done for one cycle and return to IDLE.
REQ-028 SHALL use a 32-bit timer and an ack counter of width ceil(log2(ACK_TIMEOUT+1)); neither SHALL wrap.
REQ-029 SHALL ignore load in any state other than IDLE, leaving the latched message unchanged.
REQ-030 SHALL, on abort=1 in any non-IDLE state, go to IDLE on the next edge with enc_start=0 and no done or err pulse; abort takes priority over every other transition in the same cycle.
REQ-031 SHALL, if abort and load are both high in IDLE, accept the load.
REQ-032 SHALL treat enc_busy dropping while in WAIT_ACK as no acknowledgement; the timeout continues.

Reset
REQ-033 SHALL, on rst=1 at any time including mid-message, immediately force state=IDLE, enc_start=0, enc_digit=0, busy=0, done=0, err=0, digit_idx=0, timer=0 and ack counter=0.
REQ-034 SHALL resume normal operation on the first clk edge after rst deasserts.

Verification
REQ-035 SHALL verify: load with digits_in=16'h0372 and num_digits=3 against an encoder model that is busy for 10 cycles, with CHAR_GAP=20 -> enc_digit sequence 3,7,2; exactly 20 idle cycles between the fall of enc_busy and the next enc_start; a single done pulse.
REQ-036 SHALL verify: num_digits=0, and separately digits_in=16'h00A1 with num_digits=2 -> err pulses once, busy stays 0, enc_start never asserts.
REQ-037 SHALL verify: enc_busy tied to 0 with ACK_TIMEOUT=16 -> err pulses 16 cycles after enc_start, then IDLE with no done.
REQ-038 SHALL verify: abort asserted during GAP of digit 2 of 4 -> IDLE next cycle, no further enc_start, no done.
REQ-039 SHALL verify: rst pulsed during WAIT_DONE -> all outputs 0 immediately; a subsequent load of 16'h0009 with num_digits=1 sends 9 and pulses done.
REQ-040 SHALL verify: load re-asserted with different digits while busy -> the original message is sent unchanged.
